// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serializer_pkg
// Purpose  : Shared types and helpers for the serializer_4bit block.
//            - state_e       : FSM state encoding (IDLE, SHIFT)
//            - DEFAULT_WIDTH : default serialized word width
//            - cnt_width()   : bit-counter width for a given word width
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serializer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // $clog2 of 2 is 1 already; the floor of 1 only guards degenerate widths
  // so the counter never collapses to a zero-width vector.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter
// Purpose  : Modulo-MODULUS bit counter with synchronous clear and increment
//            enable. An increment at terminal count loads zero.
// Ports    : clk         - rising-edge clock
//            reset_n     - synchronous active-low reset
//            clr_i       - synchronous clear (priority over increment)
//            inc_i       - increment enable
//            count_o     - current count
//            tc_o        - count equals MODULUS-1
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter
  import serializer_pkg::*;
#(
  parameter int MODULUS = DEFAULT_WIDTH,
  parameter int CNT_W   = cnt_width(MODULUS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = (count_q == C_LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/serializer_4bit.sv
`default_nettype none
// ============================================================================
// Module   : serializer_4bit
// Purpose  : Parallel-in, serial-out converter. Accepts a WIDTH-bit word over
//            a valid/ready handshake and drains it one bit per downstream
//            transfer, with first/last framing and zero-bubble back-to-back
//            frames.
// Ports    : clk         - rising-edge clock
//            reset_n     - synchronous active-low reset
//            D           - parallel word, sampled only on an input transfer
//            in_valid    - D holds a word
//            in_ready    - block accepts D this cycle
//            sout        - current serial bit
//            sout_valid  - sout is valid
//            sout_ready  - downstream consumes sout this cycle
//            sout_first  - current bit is first of its word
//            sout_last   - current bit is last of its word
//            busy        - a word is in flight
// Revision : 1.0 - initial release
// ============================================================================
module serializer_4bit
  import serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] D,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  logic [WIDTH-1:0] w_shifted;
  logic             w_sout_bit;
  logic [CNT_W-1:0] w_count;
  logic             w_tc;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_shift_st;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Bit-order selection: the serial bit is always taken from the end the
  // register shifts toward, with zeros filling in behind.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted  = {shreg_q[WIDTH-2:0], 1'b0};
      assign w_sout_bit = shreg_q[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted  = {1'b0, shreg_q[WIDTH-1:1]};
      assign w_sout_bit = shreg_q[0];
    end
  endgenerate

  mod_counter #(
    .MODULUS (WIDTH),
    .CNT_W   (CNT_W)
  ) u_bit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (w_cnt_clr),
    .inc_i   (w_cnt_inc),
    .count_o (w_count),
    .tc_o    (w_tc)
  );

  assign w_shift_st = (state_q == ST_SHIFT);

  assign sout       = w_sout_bit;
  assign sout_valid = w_shift_st;
  assign busy       = w_shift_st;
  assign sout_first = w_shift_st & (w_count == '0);
  assign sout_last  = w_shift_st & w_tc;

  // Ready depends only on state and sout_ready, never on in_valid, so
  // upstream can never form a combinational loop through this block.
  assign in_ready   = reset_n & (~w_shift_st | (sout_last & sout_ready));

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = sout_valid & sout_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_in_xfer) begin
          state_d   = ST_SHIFT;
          shreg_d   = D;
          w_cnt_clr = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_out_xfer) begin
          if (w_tc) begin
            // Counter is cleared rather than incremented on the last bit so
            // it never wraps past WIDTH-1.
            w_cnt_clr = 1'b1;
            if (w_in_xfer) begin
              shreg_d = D;
            end else begin
              state_d = ST_IDLE;
              shreg_d = w_shifted;
            end
          end else begin
            shreg_d   = w_shifted;
            w_cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serializer_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_serializer_4bit
// Purpose  : Self-checking bench for serializer_4bit. Drives one MSB-first and
//            one LSB-first instance from shared stimulus and checks both
//            against a word/index model every cycle, plus literal sequences.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_serializer_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] D;
  logic         in_valid;
  logic         sout_ready;

  logic in_ready_m, sout_m, sout_valid_m, sout_first_m, sout_last_m, busy_m;
  logic in_ready_l, sout_l, sout_valid_l, sout_first_l, sout_last_l, busy_l;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serializer_4bit #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk        (clk),
    .reset_n    (reset_n),
    .D          (D),
    .in_valid   (in_valid),
    .in_ready   (in_ready_m),
    .sout       (sout_m),
    .sout_valid (sout_valid_m),
    .sout_ready (sout_ready),
    .sout_first (sout_first_m),
    .sout_last  (sout_last_m),
    .busy       (busy_m)
  );

  serializer_4bit #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk        (clk),
    .reset_n    (reset_n),
    .D          (D),
    .in_valid   (in_valid),
    .in_ready   (in_ready_l),
    .sout       (sout_l),
    .sout_valid (sout_valid_l),
    .sout_ready (sout_ready),
    .sout_first (sout_first_l),
    .sout_last  (sout_last_l),
    .busy       (busy_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a frame is "the word" plus "which bit index is on the line".
  bit           started = 1'b0;
  bit           active  = 1'b0;
  int           idx     = 0;
  logic [W-1:0] word    = '0;
  bit           m_rdy, m_inx, m_outx;

  always @(posedge clk) begin
    if (!reset_n) begin
      started = 1'b1;
      active  = 1'b0;
      idx     = 0;
      word    = '0;
    end else begin
      m_rdy  = !active || (idx == W-1 && sout_ready);
      m_inx  = in_valid && m_rdy;
      m_outx = active && sout_ready;
      if (!active) begin
        if (m_inx) begin
          active = 1'b1;
          idx    = 0;
          word   = D;
        end
      end else if (m_outx) begin
        if (idx == W-1) begin
          idx = 0;
          if (m_inx) word = D;
          else begin
            active = 1'b0;
            word   = '0;
          end
        end else begin
          idx++;
        end
      end
    end
  end

  // Transferred serial bits, in order, for literal sequence checks.
  bit q_m[$];
  bit q_l[$];

  logic e_bit_m, e_bit_l, e_first, e_last, e_rdy;

  always @(negedge clk) begin
    if (started) begin
      e_bit_m = active ? word[W-1-idx] : 1'b0;
      e_bit_l = active ? word[idx] : 1'b0;
      e_first = active && (idx == 0);
      e_last  = active && (idx == W-1);
      e_rdy   = reset_n && (!active || (e_last && sout_ready));
      chk("m_sout",       sout_m,       e_bit_m);
      chk("m_sout_valid", sout_valid_m, active);
      chk("m_sout_first", sout_first_m, e_first);
      chk("m_sout_last",  sout_last_m,  e_last);
      chk("m_busy",       busy_m,       active);
      chk("m_in_ready",   in_ready_m,   e_rdy);
      chk("l_sout",       sout_l,       e_bit_l);
      chk("l_sout_valid", sout_valid_l, active);
      chk("l_sout_first", sout_first_l, e_first);
      chk("l_sout_last",  sout_last_l,  e_last);
      chk("l_busy",       busy_l,       active);
      chk("l_in_ready",   in_ready_l,   e_rdy);
      if (sout_valid_m && sout_ready) q_m.push_back(sout_m);
      if (sout_valid_l && sout_ready) q_l.push_back(sout_l);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // exp holds the expected sequence with the first bit in position n-1.
  task automatic chk_log(input string name, input bit lsb_inst, input logic [15:0] exp, input int n);
    logic [15:0] got;
    int          sz;
    got = '0;
    sz  = lsb_inst ? q_l.size() : q_m.size();
    chk({name, "_len"}, sz, n);
    for (int i = 0; i < n && i < sz; i++) begin
      got = {got[14:0], (lsb_inst ? q_l[i] : q_m[i])};
    end
    chk({name, "_bits"}, got, exp);
  endtask

  task automatic clr_logs();
    q_m.delete();
    q_l.delete();
  endtask

  initial begin
    reset_n    = 1'b0;
    D          = '0;
    in_valid   = 1'b0;
    sout_ready = 1'b1;
    ticks(2);
    chk("reset_sout_valid", sout_valid_m, 1'b0);
    chk("reset_busy", busy_m, 1'b0);
    chk("reset_in_ready", in_ready_m, 1'b0);
    reset_n = 1'b1;
    // sout_ready low in IDLE has no effect
    sout_ready = 1'b0;
    ticks(2);
    sout_ready = 1'b1;

    // Basic frame
    clr_logs();
    D = 4'b1011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; D = 4'b0110;
    ticks(5);
    chk("basic_idle_ready", in_ready_m, 1'b1);
    chk_log("basic_msb", 1'b0, 16'b1011, 4);
    chk_log("basic_lsb", 1'b1, 16'b1101, 4);

    // Back-to-back
    clr_logs();
    D = 4'hA; in_valid = 1'b1;
    tick();
    D = 4'h5;
    ticks(4);
    in_valid = 1'b0;
    ticks(5);
    chk_log("b2b_msb", 1'b0, 16'b1010_0101, 8);
    chk_log("b2b_lsb", 1'b1, 16'b0101_1010, 8);

    // Stall on bit index 1
    clr_logs();
    D = 4'b1100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    sout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_sout", sout_m, 1'b1);
      chk("stall_first", sout_first_m, 1'b0);
    end
    sout_ready = 1'b1;
    ticks(4);
    chk_log("stall_msb", 1'b0, 16'b1100, 4);
    chk_log("stall_lsb", 1'b1, 16'b0011, 4);

    // Reset mid-frame at bit index 2
    D = 4'b1011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ticks(2);
    reset_n = 1'b0;
    tick();
    chk("rst_sout_valid", sout_valid_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_sout", sout_m, 1'b0);
    chk("rst_in_ready_low", in_ready_m, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready_high", in_ready_m, 1'b1);
    clr_logs();
    D = 4'b0110; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("rst_next_first", sout_first_m, 1'b1);
    ticks(5);
    chk_log("rst_msb", 1'b0, 16'b0110, 4);
    chk_log("rst_lsb", 1'b1, 16'b0110, 4);

    // Hold in SHIFT: D churns while in_valid is high mid-frame
    clr_logs();
    D = 4'b1001; in_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      D = 4'($urandom_range(0, 15));
      tick();
    end
    D = 4'b0011;
    tick();
    in_valid = 1'b0; D = 4'b1111;
    ticks(5);
    chk_log("hold_msb", 1'b0, 16'b1001_0011, 8);
    chk_log("hold_lsb", 1'b1, 16'b1001_1100, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serializer_4bit.md
# serializer_4bit

Parallel-in, serial-out converter that drains a WIDTH-bit register word onto a one-bit serial line, one bit per accepted cycle. Sits downstream of the parallel load registers: upstream presents a word with a valid/ready handshake, and the block shifts it out under a downstream valid/ready handshake with first/last framing. A two-state FSM and a bit counter govern acceptance, stalling and back-to-back frames.

## Interface
Parameters:
- WIDTH, 4, word width in bits (≥2)
- MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first, 0 = bit 0 first

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  reset, synchronous and active-low
- D  input  WIDTH  parallel word to serialize
- in_valid  input  1  D holds a word to transfer
- in_ready  output  1  block can accept D this cycle
- sout  output  1  current serial bit
- sout_valid  output  1  sout holds a valid bit
- sout_ready  input  1  downstream consumes sout this cycle
- sout_first  output  1  current bit is the first of its word
- sout_last  output  1  current bit is the last of its word
- busy  output  1  a word is in flight

## Operation
- Reset: when reset_n is low at a rising edge, state = IDLE, shift register = 0, bit counter = 0. All registered outputs are 0: sout, sout_valid, sout_first, sout_last and busy. in_ready is forced to 0 while reset_n is low.
- States:
  - IDLE: sout_valid = 0, in_ready = 1.
  - SHIFT: sout_valid = 1, busy = 1.
- Transfers:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = sout_valid & sout_ready at a rising edge.
- IDLE → SHIFT on an input transfer:
  - D is captured into the shift register.
  - Bit counter = 0.
- In SHIFT, on each output transfer:
  - The shift register moves one position (left if MSB_FIRST, else right), with 0 shifted in.
  - The bit counter increments.
- Without an output transfer, the shift register, bit counter and sout hold unchanged (stall of any length).
- Output decoding:
  - sout = shift register bit WIDTH-1 (MSB_FIRST) or bit 0.
  - sout_first = SHIFT & counter == 0.
  - sout_last = SHIFT & counter == WIDTH-1.
- Last bit: on an output transfer with counter == WIDTH-1:
  - If an input transfer occurs in the same cycle, load the new D, reset the counter to 0 and stay in SHIFT (back-to-back frames with no bubble).
  - Otherwise go to IDLE.
- in_ready = IDLE | (sout_last & sout_ready). This is combinational from state and sout_ready. No combinational path from in_valid to in_ready.
- D is sampled only at an input transfer; changes to D at any other time have no effect.
- Counter width is $clog2(WIDTH). The counter never exceeds WIDTH-1 and no wrap past WIDTH-1 is permitted.

## Timing
- Latency:
  - First bit is valid in the cycle after the input transfer edge.
  - A word with no stalls occupies exactly WIDTH consecutive sout_valid cycles.
- Throughput: one word per WIDTH cycles with in_valid and sout_ready held high; sout_valid is never deasserted between frames.
- Simultaneous events:
  - A reset assertion at an edge overrides any input or output transfer at that edge.
  - A frame interrupted by reset is discarded, not resumed.
- in_valid in SHIFT before the last bit: no transfer takes place. Upstream must hold D and in_valid until in_ready.
- sout_ready low in IDLE: no effect.

## Structure
- Shared package serializer_pkg holds:
  - the state typedef (enum IDLE, SHIFT)
  - the default WIDTH constant
  - the counter-width function (clog2 wrapper)
- One sub-module, mod_counter: parameterized modulo-WIDTH counter with synchronous clear, load-zero and increment-enable, plus a terminal-count output driving sout_last.
- FSM, shift register and handshake logic live in serializer_4bit.

## Test plan
- Basic frame (WIDTH=4, MSB_FIRST=1, sout_ready=1):
  - Stimulus: D=4'b1011 accepted at cycle 0.
  - Response: sout = 1,0,1,1 in cycles 1–4; sout_first in cycle 1 only, sout_last in cycle 4 only; IDLE and in_ready=1 in cycle 5.
- LSB-first (MSB_FIRST=0):
  - Stimulus: D=4'b1011.
  - Response: sout = 1,1,0,1; framing identical to the basic frame.
- Back-to-back:
  - Stimulus: D=4'hA then D=4'h5, in_valid held high.
  - Response: sout = 1,0,1,0,0,1,0,1 over 8 consecutive cycles with sout_valid high throughout; in_ready high only on the two accept cycles.
- Stall:
  - Stimulus: D=4'b1100, sout_ready dropped for 3 cycles while on bit index 1.
  - Response: sout=1 and sout_first=0 held for the 3 cycles; the frame completes as 1,1,0,0 with no bit lost or duplicated.
- Reset mid-frame:
  - Stimulus: reset_n low for one edge during bit index 2.
  - Response: the next cycle shows sout_valid=0, busy=0, sout=0; in_ready=0 while reset_n is low and 1 after release; the next word starts with sout_first=1.
- Hold in SHIFT:
  - Stimulus: in_valid high mid-frame with D changing each cycle.
  - Response: the current frame is unaffected; the new word is accepted only at the last-bit transfer.
